// File: rtl/regfile_write_scheduler_pkg.sv
// Shared widths, zero-register index and grant encoding
// for the register file write scheduler.
package regfile_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] ZERO_REG = '0;

  localparam logic GRANT_REQ0 = 1'b0;
  localparam logic GRANT_REQ1 = 1'b1;

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Writeback request channel: valid/ready handshake
// carrying a destination register and its data.
interface regfile_write_scheduler_if;
  import regfile_pkg::*;

  logic                  valid;
  logic                  ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;

  modport master (
    output valid,
    output addr,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  addr,
    input  data,
    output ready
  );

endinterface

// File: rtl/regfile_write_scheduler_arb.sv
// Two-input round-robin arbiter; history only moves
// on contention, and reset favours req0.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);

  logic last_grant;
  logic contend;

  assign contend = valid0 & valid1;

  assign grant0 = valid0 &
    (~valid1 | (last_grant == GRANT_REQ1));
  assign grant1 = valid1 &
    (~valid0 | (last_grant == GRANT_REQ0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GRANT_REQ1;
    end else if (contend) begin
      last_grant <= grant0 ? GRANT_REQ0
                           : GRANT_REQ1;
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Shares the register file write port between ALU and
// load writeback, tracking in-flight destinations.
module regfile_write_scheduler
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_write_scheduler_if.slave req0,
  regfile_write_scheduler_if.slave req1,
  output logic                  rf_write,
  output logic [ADDR_WIDTH-1:0] rf_addr_in,
  output logic [DATA_WIDTH-1:0] rf_data_in,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_dest,
  input  logic                  issue_has_dest,
  input  logic [ADDR_WIDTH-1:0] src_a,
  input  logic [ADDR_WIDTH-1:0] src_b,
  output logic                  stall,
  output logic [NUM_REGS-1:0]   busy_mask
);

  logic                  grant0;
  logic                  grant1;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_data;
  logic                  set_en;
  logic                  haz_a;
  logic                  haz_b;
  logic                  haz_d;
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_next;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid0 (req0.valid),
    .valid1 (req1.valid),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign req0.ready = grant0;
  assign req1.ready = grant1;
  assign accept     = grant0 | grant1;

  always_comb begin
    acc_addr = ZERO_REG;
    acc_data = '0;
    unique case (1'b1)
      grant0: begin
        acc_addr = req0.addr;
        acc_data = req0.data;
      end
      grant1: begin
        acc_addr = req1.addr;
        acc_data = req1.data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_write   <= 1'b0;
      rf_addr_in <= ZERO_REG;
      rf_data_in <= '0;
    end else begin
      rf_write <= accept && (acc_addr != ZERO_REG);
      if (accept) begin
        rf_addr_in <= acc_addr;
        rf_data_in <= acc_data;
      end
    end
  end

  assign haz_a = busy[src_a] && (src_a != ZERO_REG);
  assign haz_b = busy[src_b] && (src_b != ZERO_REG);
  assign haz_d = issue_has_dest && busy[issue_dest] &&
                 (issue_dest != ZERO_REG);
  assign stall = issue_valid && (haz_a || haz_b || haz_d);

  assign set_en = issue_valid && issue_has_dest &&
                  !stall && (issue_dest != ZERO_REG);

  // Clear first so a same-edge set on that register wins
  always_comb begin
    busy_next = busy;
    if (rf_write) busy_next[rf_addr_in] = 1'b0;
    if (set_en)   busy_next[issue_dest] = 1'b1;
    busy_next[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  assign busy_mask = busy;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for the register file write scheduler:
// arbitration, write latency, scoreboard and async reset.
module tb_regfile_write_scheduler;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rf_write;
  logic [ADDR_WIDTH-1:0] rf_addr_in;
  logic [DATA_WIDTH-1:0] rf_data_in;
  logic issue_valid = 1'b0;
  logic [ADDR_WIDTH-1:0] issue_dest = '0;
  logic issue_has_dest = 1'b0;
  logic [ADDR_WIDTH-1:0] src_a = '0;
  logic [ADDR_WIDTH-1:0] src_b = '0;
  logic stall;
  logic [NUM_REGS-1:0] busy_mask;

  int checks = 0;
  int errors = 0;

  regfile_write_scheduler_if r0 ();
  regfile_write_scheduler_if r1 ();

  regfile_write_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req0           (r0),
    .req1           (r1),
    .rf_write       (rf_write),
    .rf_addr_in     (rf_addr_in),
    .rf_data_in     (rf_data_in),
    .issue_valid    (issue_valid),
    .issue_dest     (issue_dest),
    .issue_has_dest (issue_has_dest),
    .src_a          (src_a),
    .src_b          (src_b),
    .stall          (stall),
    .busy_mask      (busy_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_issue();
    issue_valid    = 1'b0;
    issue_has_dest = 1'b0;
    issue_dest     = '0;
    src_a          = '0;
    src_b          = '0;
  endtask

  initial begin
    logic [DATA_WIDTH-1:0] d0;
    logic [DATA_WIDTH-1:0] d1;
    r0.valid = 1'b0; r0.addr = '0; r0.data = '0;
    r1.valid = 1'b0; r1.addr = '0; r1.data = '0;

    #12;
    check("rst_rf_write", 64'(rf_write), 64'd0);
    check("rst_rf_addr", 64'(rf_addr_in), 64'd0);
    check("rst_rf_data", 64'(rf_data_in), 64'd0);
    check("rst_busy", 64'(busy_mask), 64'd0);
    rst_n = 1'b1;
    step();

    // single ALU write
    r0.valid = 1'b1; r0.addr = 5'd3;
    r0.data = 32'hDEADBEEF;
    #1;
    check("t1_ready0", 64'(r0.ready), 64'd1);
    check("t1_ready1", 64'(r1.ready), 64'd0);
    step();
    r0.valid = 1'b0;
    check("t1_wr", 64'(rf_write), 64'd1);
    check("t1_addr", 64'(rf_addr_in), 64'd3);
    check("t1_data", 64'(rf_data_in), 64'hDEADBEEF);
    step();
    check("t1_wr_off", 64'(rf_write), 64'd0);

    // contention: alternating grants
    d0 = 32'h100; d1 = 32'h200;
    r0.valid = 1'b1; r0.addr = 5'd1; r0.data = d0;
    r1.valid = 1'b1; r1.addr = 5'd2; r1.data = d1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t2_ready0", 64'(r0.ready),
            64'(i % 2 == 0));
      check("t2_ready1", 64'(r1.ready),
            64'(i % 2 == 1));
      step();
      check("t2_wr", 64'(rf_write), 64'd1);
      if (i % 2 == 0) begin
        check("t2_addr", 64'(rf_addr_in), 64'd1);
        check("t2_data", 64'(rf_data_in), 64'(d0));
        d0 = d0 + 1; r0.data = d0;
      end else begin
        check("t2_addr", 64'(rf_addr_in), 64'd2);
        check("t2_data", 64'(rf_data_in), 64'(d1));
        d1 = d1 + 1; r1.data = d1;
      end
    end
    r0.valid = 1'b0; r1.valid = 1'b0;
    step();

    // RAW on r5
    issue_valid = 1'b1; issue_has_dest = 1'b1;
    issue_dest = 5'd5;
    #1;
    check("t3_no_stall", 64'(stall), 64'd0);
    step();
    check("t3_busy_set", 64'(busy_mask), 64'h20);
    issue_has_dest = 1'b0; issue_dest = '0;
    src_a = 5'd5;
    r0.valid = 1'b1; r0.addr = 5'd5; r0.data = 32'h55;
    #1;
    check("t3_stall", 64'(stall), 64'd1);
    step();
    r0.valid = 1'b0;
    check("t3_wr5", 64'(rf_write), 64'd1);
    check("t3_stall_wr", 64'(stall), 64'd1);
    check("t3_busy_wr", 64'(busy_mask), 64'h20);
    step();
    check("t3_release", 64'(stall), 64'd0);
    check("t3_busy_clr", 64'(busy_mask), 64'd0);

    // zero register write
    idle_issue();
    issue_valid = 1'b1; src_a = '0;
    r1.valid = 1'b1; r1.addr = '0; r1.data = 32'h1234;
    #1;
    check("t4_ready1", 64'(r1.ready), 64'd1);
    check("t4_no_stall", 64'(stall), 64'd0);
    step();
    r1.valid = 1'b0;
    check("t4_no_wr", 64'(rf_write), 64'd0);
    check("t4_busy", 64'(busy_mask), 64'd0);

    // WAW on r7
    idle_issue();
    issue_valid = 1'b1; issue_has_dest = 1'b1;
    issue_dest = 5'd7;
    step();
    check("t5_busy7", 64'(busy_mask), 64'h80);
    idle_issue();
    r1.valid = 1'b1; r1.addr = 5'd7; r1.data = 32'h77;
    step();
    r1.valid = 1'b0;
    check("t5_wr7", 64'(rf_write), 64'd1);
    issue_valid = 1'b1; issue_has_dest = 1'b1;
    issue_dest = 5'd7;
    #1;
    check("t5_waw_stall", 64'(stall), 64'd1);
    step();
    check("t5_no_set", 64'(busy_mask), 64'd0);

    // set/clear collision on r7
    idle_issue();
    r0.valid = 1'b1; r0.addr = 5'd7; r0.data = 32'h70;
    step();
    r0.valid = 1'b0;
    issue_valid = 1'b1; issue_has_dest = 1'b1;
    issue_dest = 5'd7;
    #1;
    check("t5_col_stall", 64'(stall), 64'd0);
    check("t5_col_wr", 64'(rf_write), 64'd1);
    step();
    idle_issue();
    check("t5_set_wins", 64'(busy_mask), 64'h80);

    // contention moves history to req0, then async reset
    r0.valid = 1'b1; r0.addr = 5'd1; r0.data = 32'hA;
    r1.valid = 1'b1; r1.addr = 5'd2; r1.data = 32'hB;
    #1;
    check("t6_pre_ready0", 64'(r0.ready), 64'd1);
    step();
    check("t6_pre_wr", 64'(rf_write), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_wr", 64'(rf_write), 64'd0);
    check("t6_rst_busy", 64'(busy_mask), 64'd0);
    check("t6_rst_addr", 64'(rf_addr_in), 64'd0);
    #1;
    rst_n = 1'b1;
    #1;
    check("t6_post_ready0", 64'(r0.ready), 64'd1);
    check("t6_post_ready1", 64'(r1.ready), 64'd0);
    step();
    r0.valid = 1'b0; r1.valid = 1'b0;
    check("t6_post_addr", 64'(rf_addr_in), 64'd1);
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
